// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: op codes, FSM states, counter width.
package mult_div_unit_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    // Ops 0..3 occupy the unit for several cycles; MTHI/MTLO complete in one edge.
    function automatic logic md_is_multicycle(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[2] & ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_md_divider.sv
// Combinational 32-bit signed/unsigned divider: truncating quotient, remainder follows dividend sign.
module mult_div_unit_md_divider (
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_signed,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_div_zero
);

    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_ovf;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    assign w_a_neg    = i_signed & i_dividend[31];
    assign w_b_neg    = i_signed & i_divisor[31];
    assign w_a_mag    = w_a_neg ? (~i_dividend + 32'd1) : i_dividend;
    assign w_b_mag    = w_b_neg ? (~i_divisor + 32'd1) : i_divisor;
    assign o_div_zero = (i_divisor == 32'd0);
    // A zero divisor is replaced so the divide array never sees x/0; the result is discarded anyway.
    assign w_b_safe   = o_div_zero ? 32'd1 : w_b_mag;
    assign w_ovf      = i_signed & (i_dividend == 32'h8000_0000) & (i_divisor == 32'hFFFF_FFFF);

    assign w_uq = w_a_mag / w_b_safe;
    assign w_ur = w_a_mag % w_b_safe;

    always_comb begin
        o_quot = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
        o_rem  = w_a_neg ? (~w_ur + 32'd1) : w_ur;
        if (w_ovf) begin
            o_quot = 32'h8000_0000;
            o_rem  = 32'd0;
        end
        if (o_div_zero) begin
            o_quot = 32'd0;
            o_rem  = 32'd0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with an ID/EX stall request.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        id_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_signed;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic signed [63:0] w_a_ext;
    logic signed [63:0] w_b_ext;
    logic signed [63:0] w_prod;
    logic [31:0]        w_quot;
    logic [31:0]        w_rem;
    logic               w_div_zero;
    logic               w_last;

    // Sign-extending only for MULT lets one 64-bit multiplier serve both signednesses.
    assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
    assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    mult_div_unit_md_divider u_div (
        .i_dividend (r_a),
        .i_divisor  (r_b),
        .i_signed   (r_signed),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    assign w_last = (r_cnt <= CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                r_a      <= src_a;
                                r_b      <= src_b;
                                r_signed <= md_is_signed(op);
                                r_cnt    <= MULT_LOAD;
                                r_busy   <= 1'b1;
                                r_state  <= ST_MUL_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_a      <= src_a;
                                r_b      <= src_b;
                                r_signed <= md_is_signed(op);
                                r_cnt    <= DIV_LOAD;
                                r_busy   <= 1'b1;
                                r_state  <= ST_DIV_RUN;
                            end
                            MD_MTHI: r_hi <= src_a;
                            MD_MTLO: r_lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL_RUN: begin
                    if (w_last) begin
                        {r_hi, r_lo} <= w_prod;
                        r_cnt        <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_DIV_RUN: begin
                    // Divide by zero still spends the full latency but leaves HI/LO untouched.
                    if (w_last) begin
                        if (!w_div_zero) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign md_stall = id_md & (r_busy | (start & md_is_multicycle(op)));

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus stall, ignored-start and mid-op reset sequences.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        id_md = 1'b0;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    vec_t vecs[17];

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .id_md    (id_md),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    // Issue one op, scramble operands right after the start edge, count busy cycles (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        src_a = $urandom;
        src_b = $urandom;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{MD_MTHI,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000, 0};
        vecs[6]  = '{MD_MTLO,  32'hCAFE_BABE, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_BABE, 0};
        vecs[7]  = '{MD_NOP6,  32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'hCAFE_BABE, 0};
        vecs[8]  = '{MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
        vecs[9]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[10] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[11] = '{MD_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[12] = '{MD_DIV,   32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 10};
        vecs[13] = '{MD_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 5};
        vecs[14] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 10};
        vecs[15] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[16] = '{MD_NOP7,  32'h0000_0005, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0003, 0};

        // Reset state and combinational stall while held in reset
        #12;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall_idle", {31'd0, md_stall}, 32'd0);
        id_md = 1'b1;
        start = 1'b1;
        op    = MD_DIV;
        #1 check("reset_stall_start_div", {31'd0, md_stall}, 32'd1);
        op = MD_MTLO;
        #1 check("reset_stall_start_mtlo", {31'd0, md_stall}, 32'd0);
        start = 1'b0;
        id_md = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // DIV in flight with id_md high; starts while busy must be ignored
        id_md = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op    = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        #1 check("stall_on_div_start", {31'd0, md_stall}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("seqA_busy_c%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("seqA_stall_c%0d", i), {31'd0, md_stall}, 32'd1);
            start = (i == 3 || i == 4);
            op    = (i == 3) ? MD_MTHI : MD_MULT;
            src_a = 32'hDEAD_BEEF;
            src_b = 32'h0000_0005;
            if (i == 6) begin
                id_md = 1'b0;
                #1 check("seqA_stall_no_id_md", {31'd0, md_stall}, 32'd0);
                id_md = 1'b1;
            end
        end
        @(negedge clk);
        check("seqA_busy_fall", {31'd0, busy}, 32'd0);
        check("seqA_stall_fall", {31'd0, md_stall}, 32'd0);
        check("seqA_hi", hi, 32'h0000_0002);
        check("seqA_lo", lo, 32'h0000_000E);
        id_md = 1'b0;
        repeat (3) @(negedge clk);
        check("seqA_no_late_write_hi", hi, 32'h0000_0002);
        check("seqA_no_late_busy", {31'd0, busy}, 32'd0);

        // MULT aborted by reset in its third busy cycle
        @(negedge clk);
        start = 1'b1;
        op    = MD_MULT;
        src_a = 32'd3;
        src_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        @(negedge clk);
        @(negedge clk);
        check("seqB_busy_c3", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("seqB_abort_busy", {31'd0, busy}, 32'd0);
        check("seqB_abort_hi", hi, 32'd0);
        check("seqB_abort_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("seqB_after_hi", hi, 32'd0);
        check("seqB_after_lo", lo, 32'd0);
        check("seqB_after_busy", {31'd0, busy}, 32'd0);
        run_op(MD_MULTU, 32'd3, 32'd4, cyc);
        check("seqB_restart_cycles", 32'(cyc), 32'd5);
        check("seqB_restart_hi", hi, 32'd0);
        check("seqB_restart_lo", lo, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal range 1..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  EX-stage mult/div or move-to-HI/LO instruction valid this cycle.
REQ-007 op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6..7 no-op.
REQ-008 src_a  input  32  rs operand (dividend/multiplicand; MTHI/MTLO data).
REQ-009 src_b  input  32  rt operand (divisor/multiplier).
REQ-010 id_md  input  1  ID stage holds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-011 busy  output  1  operation in progress.
REQ-012 md_stall  output  1  stall request into the stall controller's ID/EX stall input.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN.
REQ-016 In IDLE, start with op 0/1 at edge t SHALL latch operands, load counter with MULT_CYCLES, enter MUL_RUN.
REQ-017 In IDLE, start with op 2/3 at edge t SHALL latch operands, load counter with DIV_CYCLES, enter DIV_RUN.
REQ-018 In IDLE, start with op 4 (5) SHALL write src_a to hi (lo) at that edge, no busy cycles; op 6/7 SHALL do nothing.
REQ-019 busy SHALL be 1 exactly for N cycles after the starting edge (N = MULT_CYCLES or DIV_CYCLES); counter decrements each cycle in RUN states.
REQ-020 At the edge where counter reaches 0, SHALL write result to {hi,lo}, return to IDLE, deassert busy; hi/lo SHALL be unchanged during RUN states.
REQ-021 MULT: {hi,lo} = signed 32x32 -> 64-bit product; MULTU unsigned.
REQ-022 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU unsigned.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-024 Divide by zero SHALL still consume DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged.
REQ-025 start while busy (any op) SHALL be ignored; operands/state unaffected.
REQ-026 md_stall SHALL be combinational: id_md & (busy | (start & op<=3)).
REQ-027 md_stall SHALL be 0 when id_md=0, regardless of busy.
REQ-028 Operands SHALL be taken only from latched copies during RUN; src_a/src_b changes after start SHALL not affect result.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0.
REQ-030 rst_n asserted mid-operation SHALL abort it with no hi/lo write; first start after release SHALL behave as from IDLE.
REQ-031 md_stall SHALL be 0 during reset unless id_md & start & op<=3 combinationally (busy is 0).

Structure
REQ-032 Op encodings (MD_MULT..MD_MTLO) and state encodings SHALL live in the shared defines include.
REQ-033 One sub-module md_divider (combinational signed/unsigned 32-bit divide with zero/overflow handling) is natural; multiply stays inline.

Verification
REQ-034 MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV -7 / 2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, hi/lo unchanged.
REQ-037 DIV in flight, id_md=1 -> md_stall=1 every busy cycle, 0 the cycle busy falls; second start during busy ignored.
REQ-038 MTHI 0x12345678 in IDLE -> hi=0x12345678 next edge, busy stays 0.
REQ-039 MULT started, rst_n pulsed low at busy cycle 3 -> busy=0, hi=lo=0 immediately, no later write.
